// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared types and defaults for the program loader
//
// Purpose: parameter defaults, loader state encoding and word packing
//          constants used by prog_loader.
// Ports:   none (package).
package prog_pkg;

    localparam int PSIZE_DEF      = 6;   // program address width
    localparam int ISIZE_DEF      = 16;  // stored word is ISIZE_DEF+1 bits
    localparam int BYTES_PER_WORD = 3;   // stream bytes packed into one word

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BYTE0 = 3'd1,
        ST_BYTE1 = 3'd2,
        ST_BYTE2 = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } ld_state_e;

    // States in which the loader is waiting for a stream byte.
    function automatic logic is_byte_state(input ld_state_e s);
        return (s == ST_BYTE0) || (s == ST_BYTE1) || (s == ST_BYTE2);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that fills program RAM
//
// Purpose: receives bytes over a valid/ready link, packs every three bytes
//          big-endian into one (Isize+1)-bit instruction word and writes the
//          words to program RAM at addresses 0,1,2,... while holding the core.
// Ports:
//   clock      in   system clock, rising edge
//   n_reset    in   asynchronous active-low reset
//   start      in   one-cycle load request, honoured in IDLE or DONE
//   count      in   words to load (clamped to 2^Psize), sampled on start
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts a byte this cycle
//   we         out  program RAM write enable, one cycle per word
//   waddr      out  program RAM write address
//   wdata      out  program RAM write data
//   busy       out  load in progress
//   done       out  load complete, held until next accepted start or reset
//   core_hold  out  keeps the core out of execution (equals busy)
module prog_loader
    import prog_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Isize = ISIZE_DEF
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             start,
    input  logic [Psize:0]   count,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             we,
    output logic [Psize-1:0] waddr,
    output logic [Isize:0]   wdata,
    output logic             busy,
    output logic             done,
    output logic             core_hold
);

    // Upper part of a word collected from BYTE0 (1 bit) and BYTE1 (8 bits).
    localparam int HI_W = 8 * (BYTES_PER_WORD - 2) + 1;
    localparam logic [Psize:0] DEPTH = {1'b1, {Psize{1'b0}}};

    ld_state_e        state_q,    state_d;
    logic [HI_W-1:0]  hi_q,       hi_d;
    logic [Psize:0]   n_q,        n_d;
    logic [Psize:0]   wcnt_q,     wcnt_d;
    logic [Psize-1:0] waddr_q,    waddr_d;
    logic [Isize:0]   wdata_q,    wdata_d;
    logic             rx_ready_q, rx_ready_d;
    logic             we_q,       we_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             xfer;
    logic [Psize:0]   n_clamped;
    logic [Psize:0]   wcnt_inc;

    always_comb begin
        xfer      = rx_valid && rx_ready_q;
        n_clamped = (count > DEPTH) ? DEPTH : count;
        wcnt_inc  = wcnt_q + 1'b1;

        state_d = state_q;
        hi_d    = hi_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d     = n_clamped;
                    wcnt_d  = '0;
                    waddr_d = '0;
                    hi_d    = '0;
                    state_d = (n_clamped == '0) ? ST_DONE : ST_BYTE0;
                end
            end
            ST_BYTE0: begin
                if (xfer) begin
                    // Only bit 0 of the first byte carries word data.
                    hi_d[HI_W-1] = rx_data[0];
                    state_d      = ST_BYTE1;
                end
            end
            ST_BYTE1: begin
                if (xfer) begin
                    hi_d[7:0] = rx_data;
                    state_d   = ST_BYTE2;
                end
            end
            ST_BYTE2: begin
                if (xfer) begin
                    // wdata only changes here, so it is stable through WRITE
                    // and keeps the last word afterwards.
                    wdata_d = (Isize + 1)'({hi_q, rx_data});
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wcnt_d = wcnt_inc;
                if (wcnt_inc < n_q) begin
                    waddr_d = waddr_q + 1'b1;
                    state_d = ST_BYTE0;
                end else begin
                    // Final word: address parks on the last location so a
                    // full-depth load never wraps back to 0.
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered: decoded from the next state.
        rx_ready_d = is_byte_state(state_d);
        we_d       = (state_d == ST_WRITE);
        busy_d     = is_byte_state(state_d) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            n_q        <= '0;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            n_q        <= n_d;
            wcnt_q     <= wcnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign core_hold = busy_q;

endmodule
